sobel_frame_ctrl: RTL and testbench
===================================

// Module: sobel_frame_ctrl
// PURPOSE
//  Frame sequencer wrapped around the sobel_top core. Accepts a raster pixel stream and feeds it to the core.
//  After the last pixel it injects zero pixels to drain the core's 3x3 line buffers.
//  Drops warm-up outputs and re-aligns the result stream to the window centre.
//  Emits that stream downstream with sof/eol markers and start/busy/done control.
// PARAMETERS
//  IMG_W   640  pixels per line (>=3)
//  IMG_H   480  lines per frame (>=3)
//  DATA_W  24   pixel width (RGB in, sobel result out)
//  CNT_W   $clog2(IMG_W*IMG_H+IMG_W+2)  beat counter width (derived, do not override)
// PORTS
//  clk           in   1       clock, all logic on rising edge
//  rst           in   1       asynchronous active-high reset
//  start         in   1       one-cycle frame start request
//  thresh_cfg    in   8       edge threshold, sampled on accepted start
//  busy          out  1       high from accepted start until done
//  done          out  1       one-cycle pulse: last output beat accepted downstream
//  s_valid       in   1       source pixel valid
//  s_ready       out  1       source pixel ready
//  s_data        in   DATA_W  source RGB pixel, raster order
//  core_thresh   out  8       threshold to core, stable for whole frame
//  core_in_valid out  1       pixel valid to core
//  core_in_ready in   1       core accepts pixel
//  core_in_data  out  DATA_W  pixel to core
//  core_out_valid in  1       core result valid
//  core_out_ready out 1       result ready to core
//  core_out_data in   DATA_W  core result
//  m_valid       out  1       result valid downstream
//  m_ready       in   1       downstream ready
//  m_data        out  DATA_W  result pixel
//  m_sof         out  1       qualifies m_valid: pixel (0,0)
//  m_eol         out  1       qualifies m_valid: last pixel of line
// BEHAVIOUR
//  Reset: state=IDLE, all counters 0, busy/done/s_ready/core_in_valid/core_out_ready/m_valid/m_sof/m_eol=0.
//    Reset also sets core_thresh=0 and core_in_data=0.
//  Core contract: one result per accepted input. Result k is the window centred on input k-(IMG_W+1).
//  Input FSM: IDLE -> FEED -> FLUSH -> WAIT -> IDLE.
//   IDLE : start=1 latches thresh_cfg into core_thresh, busy<=1, -> FEED. start while busy is ignored.
//   FEED : s_ready=core_in_ready, core_in_valid=s_valid, core_in_data=s_data (combinational pass).
//          in_cnt++ per core handshake. Core handshake #IMG_W*IMG_H -> FLUSH.
//   FLUSH: s_ready=0, core_in_valid=1, core_in_data=0. Exactly IMG_W+1 accepted beats -> WAIT.
//   WAIT : no input activity. Last forwarded output accepted (m_valid&m_ready) -> done=1 for 1 cycle.
//          Same cycle busy<=0 and -> IDLE. start is honoured again the following cycle.
//  Output path runs concurrently from FEED onward; out_cnt counts core output handshakes.
//   out_cnt < IMG_W+1  : discard. core_out_ready=1, m_valid=0.
//   otherwise forward  : m_valid=core_out_valid, core_out_ready=m_ready, m_data=core_out_data (no latency).
//   col/row counters track forwarded pixels. col wraps at IMG_W-1, then row++.
//   m_sof=(row==0&&col==0). m_eol=(col==IMG_W-1).
//  Exactly IMG_W*IMG_H beats are forwarded per frame.
//  Extra core outputs or source beats outside FEED are never accepted (ready=0).
//  m_valid held with m_data stable until m_ready. Backpressure stalls the core, never drops data.
//  Async reset mid-frame: immediate return to IDLE, no done pulse.
//    The core is not reset by this block; its parent resets both together.
// CONFIGURATION
//  SOBEL_CTRL_BORDER_ZERO_EN defined: forwarded pixels with row==0, row==IMG_H-1, col==0 or col==IMG_W-1 are output as m_data=0.
//    These are pixels whose window is incomplete. Handshake timing is unchanged.
//  Not defined: core_out_data passes through unmodified for every pixel.
// TESTING  (IMG_W=4, IMG_H=3 unless noted)
//  Reset/idle: rst pulsed mid-FEED -> busy=0, s_ready=0, m_valid=0 same cycle. A new start gives a full 12-pixel frame.
//  Nominal frame: start, thresh_cfg=30, 12 pixels back-to-back -> 5 core outputs discarded, 12 forwarded.
//    m_sof on beat 0, m_eol on beats 3/7/11, done 1 cycle after beat 11, core_thresh=30 whole frame.
//  Flush: after pixel 12, core_in_data=0 with core_in_valid=1 for exactly 5 handshakes; s_ready=0 throughout.
//  Backpressure: m_ready toggled 1/0 and core_in_ready random -> no lost/duplicated beats, m_data stable while stalled.
//  Border (macro on): constant input, core result 0xFFFFFF -> only beats 5 and 6 nonzero. Macro off -> all 12 = 0xFFFFFF.
//  Start while busy: start pulse in FEED with thresh_cfg=99 -> ignored, core_thresh stays 30, frame count unaffected.

Source files
------------

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer around the sobel core: feeds one raster frame, drains the line buffers with zero
// pixels, drops warm-up results and emits a centre-aligned stream. Optional macro: SOBEL_CTRL_BORDER_ZERO_EN.
module sobel_frame_ctrl #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int DATA_W = 24,
    parameter int CNT_W  = $clog2(IMG_W*IMG_H+IMG_W+2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        thresh_cfg,
    output logic              busy,
    output logic              done,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic [7:0]        core_thresh,
    output logic              core_in_valid,
    input  logic              core_in_ready,
    output logic [DATA_W-1:0] core_in_data,
    input  logic              core_out_valid,
    output logic              core_out_ready,
    input  logic [DATA_W-1:0] core_out_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sof,
    output logic              m_eol
);

    // Handshakes: a beat transfers on a rising edge where valid and ready are both high;
    // valid never waits on ready, and a held valid keeps its data stable until accepted.

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FEED  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(IMG_W*IMG_H - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(IMG_W*IMG_H + IMG_W);
    localparam logic [CNT_W-1:0] SKIP       = CNT_W'(IMG_W + 1);
    localparam logic [CNT_W-1:0] OUT_LAST   = CNT_W'(IMG_W*IMG_H + IMG_W);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(IMG_H - 1);

    logic [1:0]       state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [7:0]       thresh_q, thresh_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             last_seen_q, last_seen_d;

    logic active, discard, fwd, out_hs, last_hs, border;

    // Result k belongs to the window centred on input k-(IMG_W+1); the first IMG_W+1 are warm-up.
    assign active  = (state_q != ST_IDLE);
    assign discard = active && (out_cnt_q < SKIP);
    assign fwd     = active && !discard && (out_cnt_q <= OUT_LAST) && !last_seen_q;
    assign out_hs  = fwd && core_out_valid && m_ready;
    assign last_hs = out_hs && (out_cnt_q == OUT_LAST);
    assign border  = (row_q == '0) || (row_q == ROW_LAST) || (col_q == '0) || (col_q == COL_LAST);

    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        thresh_d      = thresh_q;
        in_cnt_d      = in_cnt_q;
        out_cnt_d     = out_cnt_q;
        col_d         = col_q;
        row_d         = row_q;
        last_seen_d   = last_seen_q;
        s_ready       = 1'b0;
        core_in_valid = 1'b0;
        core_in_data  = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_FEED;
                    busy_d      = 1'b1;
                    thresh_d    = thresh_cfg;
                    in_cnt_d    = '0;
                    out_cnt_d   = '0;
                    col_d       = '0;
                    row_d       = '0;
                    last_seen_d = 1'b0;
                end
            end
            ST_FEED: begin
                s_ready       = core_in_ready;
                core_in_valid = s_valid;
                core_in_data  = s_data;
                if (s_valid && core_in_ready) begin
                    in_cnt_d = in_cnt_q + 1'b1;
                    if (in_cnt_q == FEED_LAST) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                core_in_valid = 1'b1;
                if (core_in_ready) begin
                    in_cnt_d = in_cnt_q + 1'b1;
                    if (in_cnt_q == FLUSH_LAST) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // A combinational core may deliver the last result before WAIT; last_seen_q remembers it.
                if (last_hs || last_seen_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        core_out_ready = 1'b0;
        m_valid        = 1'b0;
        m_data         = '0;
        m_sof          = 1'b0;
        m_eol          = 1'b0;
        if (discard) begin
            core_out_ready = 1'b1;
            if (core_out_valid) begin
                out_cnt_d = out_cnt_q + 1'b1;
            end
        end else if (fwd) begin
            m_valid        = core_out_valid;
            core_out_ready = m_ready;
`ifdef SOBEL_CTRL_BORDER_ZERO_EN
            m_data         = border ? '0 : core_out_data;
`else
            m_data         = core_out_data;
`endif
            m_sof          = core_out_valid && (row_q == '0) && (col_q == '0);
            m_eol          = core_out_valid && (col_q == COL_LAST);
            if (out_hs) begin
                out_cnt_d = out_cnt_q + 1'b1;
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
                if (last_hs) begin
                    last_seen_d = 1'b1;
                end
            end
        end
    end

`ifndef SOBEL_CTRL_BORDER_ZERO_EN
    logic unused_border;
    assign unused_border = border;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            thresh_q    <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            col_q       <= '0;
            row_q       <= '0;
            last_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            thresh_q    <= thresh_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            col_q       <= col_d;
            row_q       <= row_d;
            last_seen_q <= last_seen_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign core_thresh = thresh_q;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl on a 4x3 frame with a behavioural one-result-per-input core.
module tb_sobel_frame_ctrl;

    localparam int IMG_W  = 4;
    localparam int IMG_H  = 3;
    localparam int DATA_W = 24;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int SKIP   = IMG_W + 1;
    localparam logic [DATA_W-1:0] XMASK = 24'h5A3C00;

    logic              clk, rst, start;
    logic [7:0]        thresh_cfg;
    logic              busy, done;
    logic              s_valid, s_ready;
    logic [DATA_W-1:0] s_data;
    logic [7:0]        core_thresh;
    logic              core_in_valid, core_in_ready;
    logic [DATA_W-1:0] core_in_data;
    logic              core_out_valid, core_out_ready;
    logic [DATA_W-1:0] core_out_data;
    logic              m_valid, m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_sof, m_eol;

    int checks = 0;
    int errors = 0;

    sobel_frame_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .start(start), .thresh_cfg(thresh_cfg),
        .busy(busy), .done(done),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .core_thresh(core_thresh),
        .core_in_valid(core_in_valid), .core_in_ready(core_in_ready), .core_in_data(core_in_data),
        .core_out_valid(core_out_valid), .core_out_ready(core_out_ready), .core_out_data(core_out_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sof(m_sof), .m_eol(m_eol)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- core model: one result per accepted input, in order ----------------
    logic [DATA_W-1:0] cq[$];
    bit core_const = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cq.delete();
            core_out_valid <= 1'b0;
            core_out_data  <= '0;
        end else begin
            if (core_out_valid && core_out_ready) void'(cq.pop_front());
            if (core_in_valid && core_in_ready)
                cq.push_back(core_const ? 24'hFFFFFF : (core_in_data ^ XMASK));
            core_out_valid <= (cq.size() != 0);
            core_out_data  <= (cq.size() != 0) ? cq[0] : '0;
        end
    end

    // ---------------- monitor (samples on the falling edge) ----------------
    logic [DATA_W-1:0] got_d[$];
    logic              got_sof[$];
    logic              got_eol[$];
    int                got_cyc[$];
    logic [DATA_W-1:0] in_log[$];
    int  cyc = 0, done_cnt = 0, done_cyc = 0;
    int  stall_viol = 0, flush_sready_viol = 0, thresh_viol = 0;
    bit  busy_at_done = 1'b0, prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    logic [7:0] exp_thresh = '0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!m_valid || m_data !== prev_data)) stall_viol++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (m_valid && m_ready) begin
                got_d.push_back(m_data);
                got_sof.push_back(m_sof);
                got_eol.push_back(m_eol);
                got_cyc.push_back(cyc);
            end
            if (in_log.size() >= NPIX && s_ready) flush_sready_viol++;
            if (core_in_valid && core_in_ready) in_log.push_back(core_in_data);
            if (done) begin
                done_cnt++;
                done_cyc     = cyc;
                busy_at_done = busy;
            end
            if (busy && core_thresh !== exp_thresh) thresh_viol++;
        end
    end

    // Expected forwarded beat j: core result j+SKIP; inputs past the frame are the zero flush pixels.
    function automatic logic [DATA_W-1:0] exp_beat(input int j, input logic [DATA_W-1:0] base, input bit cmode);
        int k;
        logic [DATA_W-1:0] src;
        k = j + SKIP;
`ifdef SOBEL_CTRL_BORDER_ZERO_EN
        if (j / IMG_W == 0 || j / IMG_W == IMG_H - 1 || j % IMG_W == 0 || j % IMG_W == IMG_W - 1) return '0;
`endif
        if (cmode) return 24'hFFFFFF;
        src = (k < NPIX) ? base + DATA_W'(k) : '0;
        return src ^ XMASK;
    endfunction

    // ---------------- driver ----------------
    task automatic run_frame(input logic [7:0] th, input logic [DATA_W-1:0] base, input bit bp,
                             input bit inject, input bit cmode, output int cycles);
        int idx;
        int d0;
        bit hs;
        got_d.delete(); got_sof.delete(); got_eol.delete(); got_cyc.delete(); in_log.delete();
        stall_viol = 0; flush_sready_viol = 0; thresh_viol = 0;
        core_const = cmode;
        d0 = done_cnt; idx = 0; cycles = 0;
        start = 1'b1; thresh_cfg = th; exp_thresh = th;
        @(posedge clk); #1;
        start = 1'b0; thresh_cfg = 8'h00;
        while (done_cnt == d0 && cycles < 2000) begin
            s_valid       = (idx < NPIX);
            s_data        = cmode ? base : base + DATA_W'(idx);
            m_ready       = bp ? cycles[0] : 1'b1;
            core_in_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            start         = inject && (cycles == 3);
            thresh_cfg    = start ? 8'd99 : 8'd0;
            @(negedge clk);
            hs = s_valid && s_ready;
            @(posedge clk); #1;
            if (hs) idx++;
            cycles++;
        end
        s_valid = 1'b0; start = 1'b0; m_ready = 1'b1; core_in_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int d0, cycles;
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %b exp 0", s_ready); end
        checks++; if (core_in_valid !== 1'b0) begin errors++; $display("FAIL reset_core_in_valid got %b exp 0", core_in_valid); end
        checks++; if (core_out_ready !== 1'b0) begin errors++; $display("FAIL reset_core_out_ready got %b exp 0", core_out_ready); end
        checks++; if ({m_valid, m_sof, m_eol} !== 3'b000) begin errors++; $display("FAIL reset_m_flags got %b exp 000", {m_valid, m_sof, m_eol}); end
        checks++; if (core_thresh !== 8'd0) begin errors++; $display("FAIL reset_core_thresh got %0d exp 0", core_thresh); end
        checks++; if (core_in_data !== '0) begin errors++; $display("FAIL reset_core_in_data got %h exp 0", core_in_data); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        // Partial frame, then asynchronous reset in the middle of FEED.
        start = 1'b1; thresh_cfg = 8'd30; exp_thresh = 8'd30;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1; s_data = 24'h000100 + DATA_W'(i);
            @(posedge clk); #1;
        end
        d0 = done_cnt;
        #1 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b exp 0", busy); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL midreset_s_ready got %b exp 0", s_ready); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midreset_m_valid got %b exp 0", m_valid); end
        s_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (done_cnt !== d0) begin errors++; $display("FAIL midreset_no_done got %0d exp %0d", done_cnt, d0); end
        run_frame(8'd30, 24'h100000, 1'b0, 1'b0, 1'b0, cycles);
        checks++; if (got_d.size() !== NPIX) begin errors++; $display("FAIL restart_count got %0d exp %0d", got_d.size(), NPIX); end
        for (int j = 0; j < got_d.size(); j++) begin
            checks++;
            if (got_d[j] !== exp_beat(j, 24'h100000, 1'b0)) begin
                errors++; $display("FAIL restart_data[%0d] got %h exp %h", j, got_d[j], exp_beat(j, 24'h100000, 1'b0));
            end
        end
    endtask

    task automatic test_nominal();
        int cycles, d0;
        d0 = done_cnt;
        run_frame(8'd30, 24'h010203, 1'b0, 1'b0, 1'b0, cycles);
        checks++; if (cycles >= 2000) begin errors++; $display("FAIL nominal_timeout got %0d cycles exp <2000", cycles); end
        checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL nominal_done_pulses got %0d exp %0d", done_cnt - d0, 1); end
        checks++; if (got_d.size() !== NPIX) begin errors++; $display("FAIL nominal_count got %0d exp %0d", got_d.size(), NPIX); end
        for (int j = 0; j < got_d.size(); j++) begin
            checks++;
            if (got_d[j] !== exp_beat(j, 24'h010203, 1'b0)) begin
                errors++; $display("FAIL nominal_data[%0d] got %h exp %h", j, got_d[j], exp_beat(j, 24'h010203, 1'b0));
            end
            checks++;
            if (got_sof[j] !== (j == 0)) begin errors++; $display("FAIL nominal_sof[%0d] got %b exp %b", j, got_sof[j], j == 0); end
            checks++;
            if (got_eol[j] !== (j % IMG_W == IMG_W - 1)) begin
                errors++; $display("FAIL nominal_eol[%0d] got %b exp %b", j, got_eol[j], j % IMG_W == IMG_W - 1);
            end
        end
        if (got_cyc.size() != 0) begin
            checks++;
            if (done_cyc !== got_cyc[got_cyc.size()-1] + 1) begin
                errors++; $display("FAIL nominal_done_timing got cyc %0d exp %0d", done_cyc, got_cyc[got_cyc.size()-1] + 1);
            end
        end
        checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL nominal_busy_at_done got %b exp 0", busy_at_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nominal_busy_after got %b exp 0", busy); end
        checks++; if (thresh_viol !== 0) begin errors++; $display("FAIL nominal_core_thresh got %0d bad cycles exp 0", thresh_viol); end
        checks++; if (core_thresh !== 8'd30) begin errors++; $display("FAIL nominal_thresh_hold got %0d exp 30", core_thresh); end
    endtask

    task automatic test_flush();
        int cycles;
        run_frame(8'd45, 24'h200010, 1'b0, 1'b0, 1'b0, cycles);
        checks++; if (in_log.size() !== NPIX + SKIP) begin errors++; $display("FAIL flush_in_count got %0d exp %0d", in_log.size(), NPIX + SKIP); end
        for (int i = 0; i < in_log.size(); i++) begin
            checks++;
            if (in_log[i] !== ((i < NPIX) ? 24'h200010 + DATA_W'(i) : 24'h000000)) begin
                errors++; $display("FAIL flush_core_in[%0d] got %h exp %h", i, in_log[i], (i < NPIX) ? 24'h200010 + DATA_W'(i) : 24'h000000);
            end
        end
        checks++; if (flush_sready_viol !== 0) begin errors++; $display("FAIL flush_s_ready got %0d cycles high exp 0", flush_sready_viol); end
    endtask

    task automatic test_backpressure();
        int cycles;
        run_frame(8'd30, 24'h300000, 1'b1, 1'b0, 1'b0, cycles);
        checks++; if (cycles >= 2000) begin errors++; $display("FAIL bp_timeout got %0d cycles exp <2000", cycles); end
        checks++; if (got_d.size() !== NPIX) begin errors++; $display("FAIL bp_count got %0d exp %0d", got_d.size(), NPIX); end
        for (int j = 0; j < got_d.size(); j++) begin
            checks++;
            if (got_d[j] !== exp_beat(j, 24'h300000, 1'b0)) begin
                errors++; $display("FAIL bp_data[%0d] got %h exp %h", j, got_d[j], exp_beat(j, 24'h300000, 1'b0));
            end
        end
        checks++; if (stall_viol !== 0) begin errors++; $display("FAIL bp_stall_stable got %0d violations exp 0", stall_viol); end
        checks++; if (in_log.size() !== NPIX + SKIP) begin errors++; $display("FAIL bp_in_count got %0d exp %0d", in_log.size(), NPIX + SKIP); end
    endtask

    task automatic test_border();
        int cycles;
        run_frame(8'd30, 24'h123456, 1'b0, 1'b0, 1'b1, cycles);
        checks++; if (got_d.size() !== NPIX) begin errors++; $display("FAIL border_count got %0d exp %0d", got_d.size(), NPIX); end
        for (int j = 0; j < got_d.size(); j++) begin
            checks++;
            if (got_d[j] !== exp_beat(j, 24'h123456, 1'b1)) begin
                errors++; $display("FAIL border_data[%0d] got %h exp %h", j, got_d[j], exp_beat(j, 24'h123456, 1'b1));
            end
        end
    endtask

    task automatic test_start_while_busy();
        int cycles, d0;
        d0 = done_cnt;
        run_frame(8'd30, 24'h400000, 1'b0, 1'b1, 1'b0, cycles);
        checks++; if (thresh_viol !== 0) begin errors++; $display("FAIL busy_start_thresh got %0d bad cycles exp 0", thresh_viol); end
        checks++; if (got_d.size() !== NPIX) begin errors++; $display("FAIL busy_start_count got %0d exp %0d", got_d.size(), NPIX); end
        checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL busy_start_done got %0d exp %0d", done_cnt - d0, 1); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle got %b exp 0", busy); end
    endtask

    task automatic test_back_to_back();
        int cycles;
        run_frame(8'd7, 24'h500000, 1'b0, 1'b0, 1'b0, cycles);
        run_frame(8'd8, 24'h600000, 1'b0, 1'b0, 1'b0, cycles);
        checks++; if (got_d.size() !== NPIX) begin errors++; $display("FAIL b2b_count got %0d exp %0d", got_d.size(), NPIX); end
        if (got_d.size() != 0) begin
            checks++;
            if (got_d[0] !== exp_beat(0, 24'h600000, 1'b0)) begin
                errors++; $display("FAIL b2b_first got %h exp %h", got_d[0], exp_beat(0, 24'h600000, 1'b0));
            end
        end
        checks++; if (core_thresh !== 8'd8) begin errors++; $display("FAIL b2b_thresh got %0d exp 8", core_thresh); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; thresh_cfg = '0;
        s_valid = 1'b0; s_data = '0; core_in_ready = 1'b1; m_ready = 1'b1;
        test_reset();
        test_nominal();
        test_flush();
        test_backpressure();
        test_border();
        test_start_while_busy();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
